imem_loader: RTL and testbench

//  Program loader that writes instruction memory from a byte stream before the core runs.
//  It sits between a host byte source and the instruction memory write port, and is the

---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host-side byte stream, instruction-memory write port and core-control status of imem_loader.
// The loader takes the slave modport; the host/test side takes the master modport.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Loads instruction memory from a length-prefixed byte stream, holding the core in reset until done.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_COLLECT,
        S_WRITE,
`ifdef CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t          r_state, w_state_next;
    logic [15:0]     r_count, w_count_next;
    logic [ADDR_W:0] r_index, w_index_next;
    logic [31:0]     r_word, w_word_next;
    logic [1:0]      r_byte_cnt, w_byte_cnt_next;
`ifdef CHECKSUM_EN
    logic [7:0]      r_csum, w_csum_next;
`endif

    logic            w_byte_ready;
    logic            w_accept;
    logic            w_last;
    logic [15:0]     w_len;

    assign w_accept = bus.byte_valid && w_byte_ready;
    assign w_len    = {r_count[15:8], bus.byte_data};
    // Index is one bit wider than the address so a full-capacity image ends without wrapping.
    assign w_last   = (32'(r_index) == (32'(r_count) - 32'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_index    <= '0;
            r_word     <= '0;
            r_byte_cnt <= '0;
`ifdef CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_index    <= w_index_next;
            r_word     <= w_word_next;
            r_byte_cnt <= w_byte_cnt_next;
`ifdef CHECKSUM_EN
            r_csum     <= w_csum_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_index_next    = r_index;
        w_word_next     = r_word;
        w_byte_cnt_next = r_byte_cnt;
`ifdef CHECKSUM_EN
        w_csum_next     = r_csum;
`endif
        w_byte_ready    = 1'b0;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    w_state_next = S_LEN_HI;
`ifdef CHECKSUM_EN
                    w_csum_next  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                w_byte_ready = 1'b1;
                if (w_accept) begin
                    w_count_next[15:8] = bus.byte_data;
                    w_state_next       = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                w_byte_ready = 1'b1;
                if (w_accept) begin
                    w_count_next = w_len;
                    if (w_len == 16'd0 || 32'(w_len) > CAPACITY) begin
                        w_state_next = S_ERROR;
                    end else begin
                        w_state_next    = S_COLLECT;
                        w_index_next    = '0;
                        w_byte_cnt_next = '0;
                    end
                end
            end
            S_COLLECT: begin
                w_byte_ready = 1'b1;
                if (w_accept) begin
                    // Shifting left leaves the first byte of the word in [31:24].
                    w_word_next     = {r_word[23:0], bus.byte_data};
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
`ifdef CHECKSUM_EN
                    w_csum_next     = r_csum ^ bus.byte_data;
`endif
                    if (r_byte_cnt == 2'd3) begin
                        w_state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (w_last) begin
`ifdef CHECKSUM_EN
                    w_state_next = S_CHECK;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_index_next = r_index + 1'b1;
                    w_state_next = S_COLLECT;
                end
            end
`ifdef CHECKSUM_EN
            S_CHECK: begin
                w_byte_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = (bus.byte_data == r_csum) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.imem_we    = (r_state == S_WRITE);
    assign bus.imem_addr  = r_index[ADDR_W-1:0];
    assign bus.imem_wdata = r_word;
    assign bus.cpu_hold   = (r_state != S_DONE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.error      = (r_state == S_ERROR);
endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: the driver queues expected writes, a monitor checks them.
// Define CHECKSUM_EN on both bench and RTL to exercise the trailing checksum byte.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk;
    logic reset;
    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [31:0] img[$];
    logic [7:0]  stream[$];
    int          cur_words = 0;
    int          acc_cnt = 0;
    bit          exp_we_next = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: the write strobe must follow the 4th byte of each word by one cycle, and match the queue.
    always @(negedge clk) begin
        if (reset) begin
            acc_cnt     = 0;
            exp_we_next = 1'b0;
        end else begin
            if (exp_we_next || bus.imem_we)
                check("we_timing", 64'(bus.imem_we), 64'(exp_we_next));
            if (bus.imem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(bus.imem_addr), 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 64'(bus.imem_addr), 64'(e.addr));
                    check("write_data", 64'(bus.imem_wdata), 64'(e.data));
                    $display("write addr=%0d data=%08h expected addr=%0d data=%08h",
                             bus.imem_addr, bus.imem_wdata, e.addr, e.data);
                end
            end
            exp_we_next = 1'b0;
            if (bus.start) begin
                acc_cnt = 0;
            end else if (bus.byte_valid && bus.byte_ready) begin
                if (acc_cnt >= 2 && ((acc_cnt - 2) % 4) == 3 && ((acc_cnt - 2) / 4) < cur_words)
                    exp_we_next = 1'b1;
                acc_cnt++;
            end
        end
    end

    task automatic check_reset_values();
        check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_imem_we",    64'(bus.imem_we),    64'd0);
        check("rst_imem_addr",  64'(bus.imem_addr),  64'd0);
        check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check("rst_cpu_hold",   64'(bus.cpu_hold),   64'd1);
        check("rst_done",       64'(bus.done),       64'd0);
        check("rst_error",      64'(bus.error),      64'd0);
    endtask

    // Reference: a length in 1..capacity writes word i of the image to address i; anything else writes nothing.
    task automatic build(input int len, input bit len_ok, input bit bad_csum);
        logic [15:0] l;
        logic [7:0]  cs;
        wr_t         e;
        l  = len[15:0];
        cs = 8'h00;
        stream = {};
        stream.push_back(l[15:8]);
        stream.push_back(l[7:0]);
        cur_words = len_ok ? len : 0;
        if (len_ok) begin
            for (int i = 0; i < len; i++) begin
                for (int b = 3; b >= 0; b--) begin
                    logic [7:0] v;
                    v = img[i][b*8 +: 8];
                    stream.push_back(v);
                    cs = cs ^ v;
                end
                e.addr = i[ADDR_W-1:0];
                e.data = img[i];
                exp_q.push_back(e);
            end
`ifdef CHECKSUM_EN
            stream.push_back(bad_csum ? (cs ^ 8'h01) : cs);
`endif
        end
        if (bad_csum && cs == 8'h00) cs = 8'h00;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // gap: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idle cycles.
    task automatic drive(input int gap);
        foreach (stream[k]) begin
            bit acc;
            int t;
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                bus.byte_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = stream[k];
            t = 0;
            do begin
                @(negedge clk);
                acc = bus.byte_ready;
                @(posedge clk); #1;
                t++;
            end while (!acc && t < 100);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout actual=not_accepted required=accepted byte=%0d", k);
                break;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input bit exp_done);
        int t;
        t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (!(bus.done || bus.error) && t < 50);
        @(negedge clk); #1;
        check({name, "_done"},       64'(bus.done),       64'(exp_done));
        check({name, "_error"},      64'(bus.error),      64'(!exp_done));
        check({name, "_cpu_hold"},   64'(bus.cpu_hold),   64'(!exp_done));
        check({name, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
        check({name, "_pending"},    64'(exp_q.size()),   64'd0);
        $display("load %s words=%0d done=%0d error=%0d expected done=%0d",
                 name, cur_words, bus.done, bus.error, exp_done);
        exp_q = {};
    endtask

    task automatic run_load(input string name, input int len, input int gap, input bit bad_csum);
        bit ok;
        ok = (len >= 1 && len <= CAP);
        build(len, ok, bad_csum);
        pulse_start();
        drive(gap);
        wait_end(name, ok && !bad_csum);
    endtask

    task automatic set_t1_image();
        img = {};
        img.push_back(32'h2008_0005);
        img.push_back(32'h8C09_0004);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;

        set_t1_image();
        run_load("basic", 2, 0, 1'b0);
        run_load("zero_len", 0, 0, 1'b0);
        run_load("overlength", CAP + 1, 0, 1'b0);
        run_load("after_error", 2, 0, 1'b0);
        run_load("throttled", 2, 1, 1'b0);

        // Partial image, then reset mid-load.
        pulse_start();
        cur_words = 1;
        stream = {8'h00, 8'h01, 8'h20, 8'h08};
        drive(0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("idle_byte_ready", 64'(bus.byte_ready), 64'd0);
        run_load("after_reset", 2, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            int len;
            len = $urandom_range(1, 12);
            img = {};
            for (int i = 0; i < len; i++) img.push_back($urandom());
            run_load($sformatf("random%0d", n), len, 2, 1'b0);
        end

        img = {};
        for (int i = 0; i < CAP; i++) img.push_back($urandom());
        run_load("full_capacity", CAP, 0, 1'b0);

`ifdef CHECKSUM_EN
        set_t1_image();
        run_load("csum_good", 2, 0, 1'b0);
        run_load("csum_bad", 2, 2, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
